pe_seq_ctrl: RTL and testbench
==============================

PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W, default 8, operand width; ACC_W, default 32, result width; MAX_LEN, default 16, max pairs per job; DONE_TMO, default 64, max cycles waiting for pe_done.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  reset  in  1  synchronous, active-high reset
  start  in  1  job request, accepted only in IDLE
  len  in  5  pairs in job, sampled with start
  busy  out  1  high whenever state != IDLE
  src_valid  in  1  operand pair available
  src_a  in  DATA_W  signed operand A
  src_b  in  DATA_W  signed operand B
  src_ready  out  1  controller takes pair this cycle
  pe_clear  out  1  synchronous clear to PE accumulator
  pe_valid  out  1  one-cycle issue pulse to PE
  pe_a  out  DATA_W  operand A to PE
  pe_b  out  DATA_W  operand B to PE
  pe_done  in  1  PE completion level
  pe_y  in  ACC_W  PE accumulated result
  res_valid  out  1  result available
  res_ready  in  1  consumer accepts result
  res_y  out  ACC_W  captured dot product
  res_err  out  1  job aborted (timeout or bad len)

Function
REQ-003 FSM states SHALL be IDLE, CLEAR, FETCH, ISSUE, WAIT_DONE, WAIT_LOW, RESULT.
REQ-004 IDLE: start=1 with 1<=len<=MAX_LEN -> latch len, go CLEAR; start with len=0 or len>MAX_LEN -> go RESULT with res_y=0, res_err=1.
REQ-005 CLEAR: pe_clear=1 for exactly one cycle, pair counter:=0, then FETCH.
REQ-006 FETCH: src_ready=1; on src_valid&&src_ready register src_a/src_b into pe_a/pe_b, go ISSUE; otherwise stay (no timeout).
REQ-007 ISSUE: pe_valid=1 for exactly one cycle, pe_a/pe_b held stable from ISSUE until WAIT_DONE exit, go WAIT_DONE.
REQ-008 WAIT_DONE: on pe_done=1 increment counter; if counter+1==len capture pe_y into res_y; go WAIT_LOW.
REQ-009 WAIT_DONE: timeout counter SHALL count cycles from entry; reaching DONE_TMO without pe_done -> res_y=0, res_err=1, go RESULT.
REQ-010 WAIT_LOW: wait for pe_done=0 (same DONE_TMO bound, timeout as REQ-009); then FETCH if counter<len, else RESULT.
REQ-011 RESULT: res_valid=1, res_y/res_err stable; on res_ready=1 go IDLE, res_valid falls next cycle.
REQ-012 start outside IDLE SHALL be ignored; src_ready SHALL be 0 outside FETCH; at most one PE operation outstanding.
REQ-013 Counters SHALL be wide enough for MAX_LEN and DONE_TMO with no wrap-around; res_y is pe_y unmodified (no extension, no saturation).
REQ-014 Minimum per-pair latency: FETCH(1)+ISSUE(1)+PE latency+WAIT_LOW(>=1) cycles; total job latency = 1 (CLEAR) + sum of per-pair latencies + 1 cycle to RESULT.

Reset
REQ-015 reset SHALL be synchronous, active-high, and take priority over all transitions, including mid-job.
REQ-016 After reset: state=IDLE; busy, src_ready, pe_clear, pe_valid, res_valid, res_err = 0; pe_a, pe_b, res_y = 0; all counters 0.
REQ-017 Reset during RESULT SHALL discard the pending result without handshake.

Structure
REQ-018 Shared package pe_pkg SHALL hold DATA_W/ACC_W defaults, the FSM state enum type and the operand/result typedefs.
REQ-019 One sub-module, pe_tmo_cnt (loadable down-counter with expiry flag), SHALL implement the done timeout; the PE itself is instantiated outside this block.

Verification
REQ-020 Bench SHALL pair pe_seq_ctrl with the real pe and cover:
  len=7, A={10,-20,30,-40,50,-60,70}, B={2,3,-4,5,-6,7,-8} -> res_y=-1640, res_err=0, exactly 7 pe_valid pulses, 1 pe_clear.
  len=1, A=-128, B=-128 -> res_y=16384; src_valid gapped 5 cycles between pairs -> result unchanged.
  len=0 -> res_valid within 2 cycles, res_err=1, res_y=0, no pe_valid.
  PE model holding pe_done=0 -> res_err=1 exactly DONE_TMO cycles after WAIT_DONE entry.
  res_ready held 0 for 10 cycles -> res_valid/res_y stable; start pulsed during job ignored.
  reset asserted mid-WAIT_DONE in job 1 -> all outputs at reset values next cycle; job 2 (len=2, 3*4, 5*6) -> res_y=42.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types for the PE sequencing controller: FSM state encoding, operand/result
// typedefs at the default widths, and the job length check.
package pe_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;
  localparam int LEN_W      = 5;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    ISSUE,
    WAIT_DONE,
    WAIT_LOW,
    RESULT
  } state_t;

  typedef logic signed [DATA_W_DEF-1:0] operand_t;
  typedef logic signed [ACC_W_DEF-1:0]  result_t;

  typedef struct packed {
    operand_t a;
    operand_t b;
  } pair_t;

  // A job must carry at least one pair and no more than the controller can count.
  function automatic logic len_ok(input logic [LEN_W-1:0] l,
                                  input logic [LEN_W-1:0] max_len);
    return (l != '0) && (l <= max_len);
  endfunction

endpackage

// File: rtl/pe_tmo_cnt.sv
// Loadable down-counter with expiry flag; bounds how long the controller waits on pe_done.
module pe_tmo_cnt #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/pe_seq_ctrl.sv
// Sequences one dot-product job through an external PE: clear, then fetch/issue/wait per pair,
// then hold the result until the consumer takes it.
//
//   state     | meaning
//   IDLE      | waiting for start; len checked here
//   CLEAR     | one-cycle pe_clear, pair counter reset
//   FETCH     | src_ready high, waiting for an operand pair
//   ISSUE     | one-cycle pe_valid with pe_a/pe_b
//   WAIT_DONE | waiting for pe_done high (bounded)
//   WAIT_LOW  | waiting for pe_done to drop (bounded)
//   RESULT    | res_valid high until res_ready
module pe_seq_ctrl
  import pe_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int MAX_LEN  = 16,
  parameter int DONE_TMO = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4:0]        len,
  output logic              busy,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              src_ready,
  output logic              pe_clear,
  output logic              pe_valid,
  output logic [DATA_W-1:0] pe_a,
  output logic [DATA_W-1:0] pe_b,
  input  logic              pe_done,
  input  logic [ACC_W-1:0]  pe_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_y,
  output logic              res_err
);

  localparam int              TMO_W     = $clog2(DONE_TMO + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  // Loaded one cycle before each wait state so the wait lasts exactly DONE_TMO cycles.
  localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(DONE_TMO - 1);

  state_t           state;
  state_t           state_nx;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_inc;
  logic             tmo_load;
  logic             tmo_en;
  logic             tmo_expired;

  assign cnt_inc  = cnt + LEN_W'(1);
  assign tmo_load = (state == ISSUE) || ((state == WAIT_DONE) && pe_done);
  assign tmo_en   = (state == WAIT_DONE) || (state == WAIT_LOW);

  pe_tmo_cnt #(
    .W(TMO_W)
  ) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .load     (tmo_load),
    .load_val (TMO_LOAD),
    .en       (tmo_en),
    .expired  (tmo_expired)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = len_ok(len, MAX_LEN_V) ? CLEAR : RESULT;
        end
      end
      CLEAR: state_nx = FETCH;
      FETCH: begin
        if (src_valid) begin
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT_DONE;
      WAIT_DONE: begin
        if (pe_done) begin
          state_nx = WAIT_LOW;
        end else if (tmo_expired) begin
          state_nx = RESULT;
        end
      end
      WAIT_LOW: begin
        if (!pe_done) begin
          state_nx = (cnt < len_q) ? FETCH : RESULT;
        end else if (tmo_expired) begin
          state_nx = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      len_q   <= '0;
      cnt     <= '0;
      pe_a    <= '0;
      pe_b    <= '0;
      res_y   <= '0;
      res_err <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            len_q   <= len;
            res_y   <= '0;
            res_err <= !len_ok(len, MAX_LEN_V);
          end
        end
        CLEAR: cnt <= '0;
        FETCH: begin
          if (src_valid) begin
            pe_a <= src_a;
            pe_b <= src_b;
          end
        end
        WAIT_DONE: begin
          if (pe_done) begin
            cnt <= cnt_inc;
            if (cnt_inc == len_q) begin
              res_y <= pe_y;
            end
          end else if (tmo_expired) begin
            res_y   <= '0;
            res_err <= 1'b1;
          end
        end
        WAIT_LOW: begin
          if (pe_done && tmo_expired) begin
            res_y   <= '0;
            res_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign src_ready = (state == FETCH);
  assign pe_clear  = (state == CLEAR);
  assign pe_valid  = (state == ISSUE);
  assign res_valid = (state == RESULT);

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench: pe_seq_ctrl driving a small behavioural multiply-accumulate PE.
module tb_pe_seq_ctrl;

  localparam int DONE_TMO = 64;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  len;
  logic        busy;
  logic        src_valid;
  logic [7:0]  src_a;
  logic [7:0]  src_b;
  logic        src_ready;
  logic        pe_clear;
  logic        pe_valid;
  logic [7:0]  pe_a;
  logic [7:0]  pe_b;
  logic        pe_done;
  logic [31:0] pe_y;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_y;
  logic        res_err;

  int checks;
  int failures;
  int n_valid;
  int n_clear;
  bit pe_hang;

  pe_seq_ctrl #(
    .DATA_W   (8),
    .ACC_W    (32),
    .MAX_LEN  (16),
    .DONE_TMO (DONE_TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .src_valid (src_valid),
    .src_a     (src_a),
    .src_b     (src_b),
    .src_ready (src_ready),
    .pe_clear  (pe_clear),
    .pe_valid  (pe_valid),
    .pe_a      (pe_a),
    .pe_b      (pe_b),
    .pe_done   (pe_done),
    .pe_y      (pe_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_y     (res_y),
    .res_err   (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PE model: 3-cycle latency after pe_valid, pe_done high for 2 cycles; pe_hang suppresses done.
  logic signed [31:0] acc;
  logic signed [31:0] prod;
  int lat;
  int hold;
  assign pe_y = acc;

  always @(posedge clk) begin
    if (reset) begin
      acc <= 0; prod <= 0; lat <= 0; hold <= 0; pe_done <= 1'b0;
    end else if (pe_clear) begin
      acc <= 0; pe_done <= 1'b0; lat <= 0; hold <= 0;
    end else if (pe_valid) begin
      prod <= 32'($signed(pe_a)) * 32'($signed(pe_b));
      lat  <= 3;
    end else if (lat != 0) begin
      lat <= lat - 1;
      if (lat == 1 && !pe_hang) begin
        acc     <= acc + prod;
        pe_done <= 1'b1;
        hold    <= 2;
      end
    end else if (hold != 0) begin
      hold <= hold - 1;
      if (hold == 1) pe_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (pe_valid) n_valid++;
    if (pe_clear) n_clear++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, $signed(obs), obs,
             $signed(exp), exp);
    end
  endtask

  task automatic pulse_start(input int l);
    @(negedge clk);
    start = 1'b1;
    len   = 5'(l);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_pair(input int a, input int b, input int gap, output bit ok);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    src_valid = 1'b1;
    src_a = 8'(a);
    src_b = 8'(b);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (src_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    src_valid = 1'b0;
  endtask

  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic finish_job(input string tag, input int y, input bit err);
    bit ok;
    wait_res(ok);
    check({tag, "_res_valid"}, 32'(ok), 32'd1);
    check({tag, "_res_y"}, res_y, 32'(y));
    check({tag, "_res_err"}, 32'(res_err), 32'(err));
    check({tag, "_src_ready_in_result"}, 32'(src_ready), 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_res_valid_fall"}, 32'(res_valid), 32'd0);
    check({tag, "_busy_fall"}, 32'(busy), 32'd0);
  endtask

  task automatic run_pairs(input string tag, input int n, input int av[8], input int bv[8],
                           input int gap, input int poke_at);
    bit ok;
    for (int i = 0; i < n; i++) begin
      send_pair(av[i], bv[i], gap, ok);
      check($sformatf("%s_pair%0d_taken", tag, i), 32'(ok), 32'd1);
      if (i == poke_at) pulse_start(1);
    end
  endtask

  initial begin
    int v0, c0, k;
    bit ok;
    checks = 0; failures = 0; n_valid = 0; n_clear = 0; pe_hang = 1'b0;
    reset = 1'b1; start = 1'b0; len = '0; src_valid = 1'b0; src_a = '0; src_b = '0;
    res_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_src_ready", 32'(src_ready), 32'd0);
    check("rst_pe_clear", 32'(pe_clear), 32'd0);
    check("rst_pe_valid", 32'(pe_valid), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_err", 32'(res_err), 32'd0);
    check("rst_pe_ab", {16'd0, pe_a, pe_b}, 32'd0);
    check("rst_res_y", res_y, 32'd0);
    reset = 1'b0;

    // len=7 mixed-sign dot product; start pulsed mid-job must be ignored
    v0 = n_valid; c0 = n_clear;
    pulse_start(7);
    check("j7_busy", 32'(busy), 32'd1);
    run_pairs("j7", 7, '{10, -20, 30, -40, 50, -60, 70, 0}, '{2, 3, -4, 5, -6, 7, -8, 0}, 0, 2);
    finish_job("j7", -1640, 1'b0);
    check("j7_pe_valid_count", 32'(n_valid - v0), 32'd7);
    check("j7_pe_clear_count", 32'(n_clear - c0), 32'd1);

    // same vectors with 5-cycle gaps between pairs
    pulse_start(7);
    run_pairs("j7g", 7, '{10, -20, 30, -40, 50, -60, 70, 0}, '{2, 3, -4, 5, -6, 7, -8, 0}, 5, -1);
    finish_job("j7g", -1640, 1'b0);

    // len=1 extreme negatives; result held under back-pressure, start in RESULT ignored
    pulse_start(1);
    run_pairs("j1", 1, '{-128, 0, 0, 0, 0, 0, 0, 0}, '{-128, 0, 0, 0, 0, 0, 0, 0}, 5, -1);
    wait_res(ok);
    check("j1_wait", 32'(ok), 32'd1);
    start = 1'b1;
    len = 5'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("j1_hold_valid", 32'(res_valid), 32'd1);
      check("j1_hold_y", res_y, 32'd16384);
    end
    start = 1'b0;
    finish_job("j1", 16384, 1'b0);

    // bad lengths go straight to an error result
    v0 = n_valid;
    pulse_start(0);
    check("len0_res_valid_fast", 32'(res_valid), 32'd1);
    finish_job("len0", 0, 1'b1);
    pulse_start(17);
    finish_job("len17", 0, 1'b1);
    check("badlen_no_pe_valid", 32'(n_valid - v0), 32'd0);

    // PE never completes: error exactly DONE_TMO cycles into WAIT_DONE
    pe_hang = 1'b1;
    pulse_start(1);
    send_pair(5, 5, 0, ok);
    check("tmo_pair_taken", 32'(ok), 32'd1);
    for (int i = 0; i < 10 && !pe_valid; i++) @(negedge clk);
    check("tmo_issue_seen", 32'(pe_valid), 32'd1);
    @(negedge clk);
    k = 0;
    for (int i = 0; i < 200 && !res_valid; i++) begin
      @(negedge clk);
      k++;
    end
    check("tmo_latency", 32'(k), 32'(DONE_TMO));
    finish_job("tmo", 0, 1'b1);
    pe_hang = 1'b0;

    // reset mid-WAIT_DONE, then a clean job
    pulse_start(3);
    send_pair(10, 2, 0, ok);
    check("rstjob_pair_taken", 32'(ok), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_src_ready", 32'(src_ready), 32'd0);
    check("midrst_pe_valid", 32'(pe_valid), 32'd0);
    check("midrst_pe_clear", 32'(pe_clear), 32'd0);
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_res_err", 32'(res_err), 32'd0);
    check("midrst_pe_ab", {16'd0, pe_a, pe_b}, 32'd0);
    check("midrst_res_y", res_y, 32'd0);
    reset = 1'b0;
    pulse_start(2);
    run_pairs("j2", 2, '{3, 5, 0, 0, 0, 0, 0, 0}, '{4, 6, 0, 0, 0, 0, 0, 0}, 0, -1);
    finish_job("j2", 42, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
